// File: rtl/div3_pkg.sv
// Shared definitions for the div3 arbiter slice: default operand width and
// the arbiter FSM state encoding.
package div3_pkg;

    localparam int DIV3_N = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/div3.sv
// Bit-serial divide-by-3: one dividend bit per cycle, MSB first, keeping a
// remainder in {0,1,2}. i_x must stay stable while the division runs.
module div3
    import div3_pkg::*;
#(
    parameter int N = DIV3_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_vld,
    input  logic [N-1:0] i_x,
    output logic         o_vld,
    output logic [N-2:0] o_y
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    logic          busy_q, busy_d;
    logic [CW-1:0] idx_q, idx_d;
    logic [1:0]    rem_q, rem_d;
    logic [N-2:0]  quo_q, quo_d;
    logic          vld_q, vld_d;

    logic [2:0]    trial;
    logic          ge;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            idx_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            vld_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            idx_q  <= idx_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            vld_q  <= vld_d;
        end
    end

    // The first quotient bit is always 0 (remainder starts at 0), so an
    // N-1 bit shift register holds the full quotient.
    always_comb begin
        trial  = {rem_q, 1'b0} + {2'b00, i_x[idx_q]};
        ge     = (trial >= 3'd3);
        busy_d = busy_q;
        idx_d  = idx_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        vld_d  = 1'b0;
        if (i_vld) begin
            busy_d = 1'b1;
            idx_d  = CW'(N - 1);
            rem_d  = '0;
            quo_d  = '0;
        end else if (busy_q) begin
            quo_d = {quo_q[N-3:0], ge};
            rem_d = ge ? 2'(trial - 3'd3) : trial[1:0];
            if (idx_q == '0) begin
                busy_d = 1'b0;
                vld_d  = 1'b1;
            end else begin
                idx_d = idx_q - 1'b1;
            end
        end
    end

    assign o_vld = vld_q;
    assign o_y   = quo_q;

endmodule

// File: rtl/div3_arb.sv
// Round-robin arbiter sharing one div3 among R requesters, one operation in
// flight; the result is held in DONE until the consumer takes it.
module div3_arb
    import div3_pkg::*;
#(
    parameter int N = DIV3_N,
    parameter int R = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [R-1:0]                   i_req,
    input  logic [R*N-1:0]                 i_x,
    output logic [R-1:0]                   o_gnt,
    output logic [N-2:0]                   o_y,
    output logic [((R>1)?$clog2(R):1)-1:0] o_id,
    output logic                           o_vld,
    input  logic                           i_rdy
);

    localparam int IW = (R > 1) ? $clog2(R) : 1;

    arb_state_e    state_q, state_d;
    logic [IW-1:0] p_q, p_d;
    logic [IW-1:0] win_q, win_d;
    logic [N-1:0]  x_q, x_d;
    logic [N-2:0]  y_q, y_d;

    logic          any_req;
    logic [IW-1:0] win_sel;
    logic [N-1:0]  x_slice [R];

    logic          div_ivld;
    logic          div_ovld;
    logic [N-2:0]  div_y;

    div3 #(.N(N)) u_div3 (
        .clk   (clk),
        .rst_n (rst_n),
        .i_vld (div_ivld),
        .i_x   (x_q),
        .o_vld (div_ovld),
        .o_y   (div_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q   <= '0;
            win_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
        end else begin
            p_q   <= p_d;
            win_q <= win_d;
            x_q   <= x_d;
            y_q   <= y_d;
        end
    end

    // Priority search starting at p and wrapping, so the last winner has
    // the lowest priority next time.
    always_comb begin
        any_req = 1'b0;
        win_sel = p_q;
        for (int i = 0; i < R; i++) begin
            logic [IW-1:0] cand;
            cand = IW'((int'(p_q) + i) % R);
            if (!any_req && i_req[cand]) begin
                any_req = 1'b1;
                win_sel = cand;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < R; k++) begin
            x_slice[k] = i_x[k*N +: N];
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (any_req)  state_d = ST_ISSUE;
            ST_ISSUE:               state_d = ST_WAIT;
            ST_WAIT:  if (div_ovld) state_d = ST_DONE;
            ST_DONE:  if (i_rdy)    state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        p_d   = p_q;
        win_d = win_q;
        x_d   = x_q;
        y_d   = y_q;
        if (state_q == ST_IDLE && any_req) begin
            win_d = win_sel;
            x_d   = x_slice[win_sel];
        end
        if (state_q == ST_WAIT && div_ovld) begin
            y_d = div_y;
        end
        if (state_q == ST_DONE && i_rdy) begin
            p_d = (win_q == IW'(R - 1)) ? '0 : win_q + 1'b1;
        end
    end

    // The grant is combinational from IDLE; gating with rst_n keeps it low
    // the instant reset is asserted even while requests are pending.
    always_comb begin
        o_gnt    = '0;
        if (rst_n && state_q == ST_IDLE && any_req) begin
            o_gnt = R'(1) << win_sel;
        end
        div_ivld = (state_q == ST_ISSUE);
        o_vld    = (state_q == ST_DONE);
        o_y      = y_q;
        o_id     = win_q;
    end

endmodule

// File: doc/div3_arb.md
DIV3_ARB -- requirements
Module: div3_arb

Interface
REQ-001 Parameter N, default 8: dividend width in bits.
REQ-002 Parameter R, default 4: number of requesters; R >= 2.
REQ-003 Port clk  input  1: single clock; all logic on rising edge.
REQ-004 Port rst_n  input  1: asynchronous active-low reset.
REQ-005 Port i_req  input  R: per-requester request level; bit k is held high until o_gnt[k].
REQ-006 Port i_x  input  R*N: packed dividends; requester k occupies bits [k*N +: N].
REQ-007 Port o_gnt  output  R: one-hot, one-cycle accept pulse; operand sampled in the same cycle.
REQ-008 Port o_y  output  N-1: quotient floor(x/3) of the accepted operand.
REQ-009 Port o_id  output  clog2(R): index of the requester that owns o_y.
REQ-010 Port o_vld  output  1: result valid; held until accepted.
REQ-011 Port i_rdy  input  1: result consumer ready; transfer occurs when o_vld && i_rdy.

Function
REQ-012 The block SHALL share one div3 instance among R requesters, one operation in flight at a time.
REQ-013 FSM states SHALL be IDLE, ISSUE, WAIT and DONE.
REQ-014 IDLE: if any i_req bit is high, the block SHALL select the winner by round-robin starting at pointer p, latch i_x slice and index, pulse o_gnt[winner], and go to ISSUE.
REQ-015 IDLE with i_req == 0 SHALL stay in IDLE with o_gnt == 0.
REQ-016 ISSUE: the block SHALL drive div3 i_vld high for exactly one cycle, then go to WAIT.
REQ-017 The div3 i_x input SHALL come from the latched operand register and stay stable from ISSUE until the end of DONE.
REQ-018 WAIT: the first cycle with div3 o_vld high SHALL latch o_y and go to DONE; div3 o_vld is ignored in all other states.
REQ-019 DONE: o_vld SHALL be high and o_y/o_id stable; on i_rdy the block SHALL go to IDLE and set p = winner+1 mod R.
REQ-020 A new grant SHALL NOT occur in the cycle o_vld && i_rdy; the earliest next grant is the following cycle (IDLE).
REQ-021 Round-robin SHALL guarantee that each continuously requesting requester is granted within R operations.
REQ-022 i_req bits dropping while not granted SHALL be legal and SHALL NOT affect the operation in flight.
REQ-023 The block SHALL add no latency beyond div3 except 2 cycles before i_vld and 1 cycle after div3 o_vld.

Reset
REQ-024 Asserting rst_n low SHALL immediately force IDLE, p=0, o_gnt=0, o_vld=0, o_y=0, o_id=0, div3 i_vld=0.
REQ-025 rst_n SHALL also reset the div3 instance; an operation in flight at reset is dropped with no result.
REQ-026 Reset deassertion SHALL be synchronised externally; the first grant may occur in the first cycle after release.

Structure
REQ-027 A shared package div3_pkg SHALL hold the FSM state encoding and the default N.
REQ-028 The existing div3 module SHALL be the only sub-module, instantiated once with parameter N.
REQ-029 Round-robin select SHALL be a combinational priority search rotated by p; no further sub-modules.

Verification
REQ-030 R=4, only req[2] with x=255, i_rdy=1 -> o_gnt=0100 one pulse, then o_vld with o_y=85, o_id=2.
REQ-031 All four requesting with x={0,2,3,254}, i_rdy=1 -> grants in order 0,1,2,3; results 0,0,1,84 with matching o_id.
REQ-032 Result held with i_rdy=0 for 5 cycles -> o_vld, o_y, o_id stable, no new o_gnt; grant follows the cycle after i_rdy=1.
REQ-033 rst_n pulsed low during WAIT -> all outputs 0 immediately; no o_vld for the dropped request; after release, the first grant goes to the lowest requesting index.
REQ-034 Exhaustive sweep of x=0..255 on a random requester with random i_rdy stalls -> every o_y equals x/3 and o_id equals the granted index.
